// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared encodings and helpers for the LSU memory controller.
// Length, bus size and FSM state definitions.
package lsu_mem_ctrl_pkg;

  localparam logic [1:0] LEN_BYTE = 2'b00;
  localparam logic [1:0] LEN_HALF = 2'b01;
  localparam logic [1:0] LEN_WORD = 2'b11;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    RESP
  } state_t;

  typedef struct packed {
    logic       wr;
    logic [1:0] len;
    logic       sign;
    logic       ale;
  } lsu_req_t;

  // The reserved 10 encoding behaves as a word.
  function automatic logic [1:0] norm_len(
    input logic [1:0] len
  );
    return (len == 2'b10) ? LEN_WORD : len;
  endfunction

  function automatic logic [1:0] len2size(
    input logic [1:0] len
  );
    logic [1:0] s;
    s = SIZE_WORD;
    unique case (1'b1)
      (len == LEN_BYTE): s = SIZE_BYTE;
      (len == LEN_HALF): s = SIZE_HALF;
      default:           s = SIZE_WORD;
    endcase
    return s;
  endfunction

  function automatic logic [3:0] strb(
    input logic [1:0] len,
    input logic [1:0] a
  );
    logic [3:0] s;
    s = 4'b1111;
    unique case (1'b1)
      (len == LEN_BYTE): s = 4'b0001 << a;
      (len == LEN_HALF): s = 4'b0011 << {a[1], 1'b0};
      default:           s = 4'b1111;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] repl(
    input logic [1:0]  len,
    input logic [31:0] d
  );
    logic [31:0] r;
    r = d;
    unique case (1'b1)
      (len == LEN_BYTE): r = {4{d[7:0]}};
      (len == LEN_HALF): r = {2{d[15:0]}};
      default:           r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_load_ext.sv
// Load lane selection and sign/zero extension.
// Purely combinational; the caller registers the result.
module lsu_load_ext
  import lsu_mem_ctrl_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  len,
  input  logic        sign,
  output logic [31:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic        ext;

  always_comb begin
    lane_b = 8'h00;
    unique case (addr_lo)
      2'd0: lane_b = rdata[7:0];
      2'd1: lane_b = rdata[15:8];
      2'd2: lane_b = rdata[23:16];
      2'd3: lane_b = rdata[31:24];
      default: lane_b = 8'h00;
    endcase
  end

  assign lane_h = addr_lo[1] ? rdata[31:16]
                             : rdata[15:0];

  always_comb begin
    data = rdata;
    ext  = 1'b0;
    unique case (1'b1)
      (len == LEN_BYTE): begin
        ext  = lane_b[7] & sign;
        data = {{24{ext}}, lane_b};
      end
      (len == LEN_HALF): begin
        ext  = lane_h[15] & sign;
        data = {{16{ext}}, lane_h};
      end
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// LSU to data-SRAM bus controller, one transaction outstanding.
// Define LSU_ALIGN_CHECK_EN to trap misaligned half/word accesses.
module lsu_mem_ctrl
  import lsu_mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [1:0]        req_len,
  input  logic              req_sign,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_ale,
  output logic              data_sram_req,
  output logic              data_sram_wr,
  output logic [1:0]        data_sram_size,
  output logic [3:0]        data_sram_wstrb,
  output logic [ADDR_W-1:0] data_sram_addr,
  output logic [31:0]       data_sram_wdata,
  input  logic              data_sram_addr_ok,
  input  logic              data_sram_data_ok,
  input  logic [31:0]       data_sram_rdata
);

  state_t      state_q, state_d;
  lsu_req_t    rq_q;
  logic [1:0]  len_n;
  logic        fire;
  logic        mis;
  logic        sreq_q;
  logic [31:0] rdata_q;
  logic [31:0] ext_data;

  assign len_n = norm_len(req_len);
  assign fire  = req_valid & req_ready;

`ifdef LSU_ALIGN_CHECK_EN
  assign mis = ((len_n == LEN_HALF) & req_addr[0]) |
               ((len_n == LEN_WORD) & (req_addr[1:0] != 2'b00));
`else
  assign mis = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Misaligned requests spend one ADDR cycle with the bus left idle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (fire) state_d = ADDR;
      ADDR: begin
        if (rq_q.ale)               state_d = RESP;
        else if (data_sram_addr_ok) state_d = DATA;
      end
      DATA: if (data_sram_data_ok) state_d = RESP;
      RESP: if (resp_ready)        state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state_q == IDLE);
    resp_valid = (state_q == RESP);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rq_q            <= '0;
      sreq_q          <= 1'b0;
      data_sram_wr    <= 1'b0;
      data_sram_size  <= 2'd0;
      data_sram_wstrb <= 4'd0;
      data_sram_addr  <= '0;
      data_sram_wdata <= 32'd0;
      rdata_q         <= 32'd0;
    end else if (fire) begin
      rq_q.wr         <= req_wr;
      rq_q.len        <= len_n;
      rq_q.sign       <= req_sign;
      rq_q.ale        <= mis;
      sreq_q          <= ~mis;
      data_sram_wr    <= req_wr;
      data_sram_size  <= len2size(len_n);
      data_sram_wstrb <= req_wr ? strb(len_n, req_addr[1:0])
                                : 4'd0;
      data_sram_addr  <= req_addr;
      data_sram_wdata <= repl(len_n, req_wdata);
      rdata_q         <= 32'd0;
    end else begin
      if (state_q == ADDR && data_sram_addr_ok)
        sreq_q <= 1'b0;
      if (state_q == DATA && data_sram_data_ok && !rq_q.wr)
        rdata_q <= ext_data;
    end
  end

  lsu_load_ext u_load_ext (
    .rdata   (data_sram_rdata),
    .addr_lo (data_sram_addr[1:0]),
    .len     (rq_q.len),
    .sign    (rq_q.sign),
    .data    (ext_data)
  );

  assign data_sram_req = sreq_q;
  assign resp_rdata    = rdata_q;

`ifdef LSU_ALIGN_CHECK_EN
  assign resp_ale = rq_q.ale & resp_valid;
`else
  assign resp_ale = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed testbench for lsu_mem_ctrl.
// Build with LSU_ALIGN_CHECK_EN to exercise the misalignment trap.
module tb_lsu_mem_ctrl;

  logic        clk;
  logic        resetn;
  logic        req_valid, req_ready, req_wr, req_sign;
  logic [1:0]  req_len;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_ale;
  logic [31:0] resp_rdata;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata;
  logic        data_sram_addr_ok, data_sram_data_ok;

  int checks = 0;
  int errors = 0;

  logic        s_rdy, s_req1, s_req2, s_rv, s_idle, s_wr, s_ale;
  logic [1:0]  s_size;
  logic [3:0]  s_strb;
  logic [31:0] s_wdata, s_addr, s_rd;
  int          nreq, nrv, nrdy;

  lsu_mem_ctrl #(.ADDR_W(32)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_wr            (req_wr),
    .req_len           (req_len),
    .req_sign          (req_sign),
    .req_addr          (req_addr),
    .req_wdata         (req_wdata),
    .resp_valid        (resp_valid),
    .resp_ready        (resp_ready),
    .resp_rdata        (resp_rdata),
    .resp_ale          (resp_ale),
    .data_sram_req     (data_sram_req),
    .data_sram_wr      (data_sram_wr),
    .data_sram_size    (data_sram_size),
    .data_sram_wstrb   (data_sram_wstrb),
    .data_sram_addr    (data_sram_addr),
    .data_sram_wdata   (data_sram_wdata),
    .data_sram_addr_ok (data_sram_addr_ok),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic txn(input logic wr,
                     input logic [1:0] len,
                     input logic sign,
                     input logic [31:0] addr,
                     input logic [31:0] wdata,
                     input logic [31:0] rdata);
    @(negedge clk);
    req_valid = 1'b1; req_wr = wr; req_len = len;
    req_sign = sign; req_addr = addr; req_wdata = wdata;
    s_rdy = req_ready;
    @(negedge clk);
    req_valid = 1'b0;
    s_req1 = data_sram_req; s_strb = data_sram_wstrb;
    s_wdata = data_sram_wdata; s_size = data_sram_size;
    s_addr = data_sram_addr; s_wr = data_sram_wr;
    data_sram_addr_ok = 1'b1;
    @(negedge clk);
    data_sram_addr_ok = 1'b0;
    s_req2 = data_sram_req;
    data_sram_data_ok = 1'b1; data_sram_rdata = rdata;
    @(negedge clk);
    data_sram_data_ok = 1'b0;
    s_rv = resp_valid; s_rd = resp_rdata; s_ale = resp_ale;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    s_idle = req_ready & ~resp_valid;
  endtask

  initial begin
    resetn = 1'b0; req_valid = 1'b0; req_wr = 1'b0;
    req_len = 2'b00; req_sign = 1'b0; req_addr = '0;
    req_wdata = '0; resp_ready = 1'b0;
    data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0;
    data_sram_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_rv", resp_valid, 0);
    chk("rst_req", data_sram_req, 0);
    chk("rst_rd", resp_rdata, 0);
    chk("rst_ale", resp_ale, 0);
    chk("rst_strb", data_sram_wstrb, 0);
    chk("rst_addr", data_sram_addr, 0);
    resetn = 1'b1;

    // Stray handshakes while idle
    @(negedge clk);
    data_sram_addr_ok = 1'b1; data_sram_data_ok = 1'b1;
    @(negedge clk);
    data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0;
    chk("idle_ok_rv", resp_valid, 0);
    chk("idle_ok_req", data_sram_req, 0);
    chk("idle_ok_rdy", req_ready, 1);

    // lb, signed, top lane
    txn(1'b0, 2'b00, 1'b1, 32'h0000_1003, 32'h0, 32'h80FF_0000);
    chk("lb_rdy", s_rdy, 1);
    chk("lb_req1", s_req1, 1);
    chk("lb_size", s_size, 0);
    chk("lb_strb", s_strb, 4'b0000);
    chk("lb_wr", s_wr, 0);
    chk("lb_addr", s_addr, 32'h0000_1003);
    chk("lb_req2", s_req2, 0);
    chk("lb_rv", s_rv, 1);
    chk("lb_rd", s_rd, 32'hFFFF_FF80);
    chk("lb_idle", s_idle, 1);

    txn(1'b0, 2'b01, 1'b0, 32'h0000_2002, 32'h0, 32'h8001_1234);
    chk("lhu_size", s_size, 1);
    chk("lhu_rd", s_rd, 32'h0000_8001);

    txn(1'b0, 2'b01, 1'b1, 32'h0000_2000, 32'h0, 32'h0000_8001);
    chk("lh_rd", s_rd, 32'hFFFF_8001);

    txn(1'b0, 2'b00, 1'b0, 32'h0000_2001, 32'h0, 32'h0000_F500);
    chk("lbu_rd", s_rd, 32'h0000_00F5);

    txn(1'b0, 2'b11, 1'b1, 32'h0000_0004, 32'h0, 32'hDEAD_BEEF);
    chk("lw_size", s_size, 2);
    chk("lw_rd", s_rd, 32'hDEAD_BEEF);

    txn(1'b0, 2'b10, 1'b0, 32'h0000_0008, 32'h0, 32'h8765_4321);
    chk("l10_size", s_size, 2);
    chk("l10_rd", s_rd, 32'h8765_4321);

    txn(1'b1, 2'b00, 1'b0, 32'h0000_3001, 32'hFFFF_FFAB, 32'hFFFF_FFFF);
    chk("sb_strb", s_strb, 4'b0010);
    chk("sb_wdata", s_wdata, 32'hABAB_ABAB);
    chk("sb_wr", s_wr, 1);
    chk("sb_rd", s_rd, 0);
    chk("sb_rv", s_rv, 1);

    txn(1'b1, 2'b01, 1'b0, 32'h0000_3002, 32'h0000_1234, 32'h0);
    chk("sh_strb", s_strb, 4'b1100);
    chk("sh_wdata", s_wdata, 32'h1234_1234);
    chk("sh_size", s_size, 1);

    txn(1'b1, 2'b11, 1'b0, 32'h0000_3008, 32'h1122_3344, 32'h0);
    chk("sw_strb", s_strb, 4'b1111);
    chk("sw_wdata", s_wdata, 32'h1122_3344);

    // Slow bus and stalled pipeline
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b0; req_len = 2'b11;
    req_sign = 1'b0; req_addr = 32'h0000_0100;
    nreq = 0; nrv = 0; nrdy = 0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (data_sram_req) nreq++;
      if (resp_valid) nrv++;
      if (k < 12 && req_ready) nrdy++;
      if (k >= 9 && k <= 11)
        chk("slow_rd", resp_rdata, 32'hCAFE_F00D);
      data_sram_addr_ok = (k == 4) || (k == 6);
      data_sram_data_ok = (k == 4) || (k == 8);
      data_sram_rdata = (k == 8) ? 32'hCAFE_F00D : 32'h1234_5678;
      resp_ready = (k == 11);
    end
    data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0;
    resp_ready = 1'b0;
    chk("slow_nreq", nreq, 5);
    chk("slow_nrv", nrv, 3);
    chk("slow_nrdy", nrdy, 0);
    chk("slow_end_rdy", req_ready, 1);

    // Reset while waiting for data, then a late data_ok
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b0; req_len = 2'b11;
    req_addr = 32'h0000_0040;
    @(negedge clk);
    req_valid = 1'b0; data_sram_addr_ok = 1'b1;
    @(negedge clk);
    data_sram_addr_ok = 1'b0;
    resetn = 1'b0;
    #1;
    chk("rdata_rst_rdy", req_ready, 1);
    chk("rdata_rst_req", data_sram_req, 0);
    chk("rdata_rst_rv", resp_valid, 0);
    chk("rdata_rst_addr", data_sram_addr, 0);
    @(negedge clk);
    resetn = 1'b1;
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h5555_AAAA;
    @(negedge clk);
    data_sram_data_ok = 1'b0;
    chk("late_ok_rv", resp_valid, 0);
    chk("late_ok_rdy", req_ready, 1);
    @(negedge clk);
    chk("late_ok_rv2", resp_valid, 0);
    chk("late_ok_rd", resp_rdata, 0);

`ifdef LSU_ALIGN_CHECK_EN
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b0; req_len = 2'b11;
    req_addr = 32'h0000_3002;
    data_sram_rdata = 32'hA5A5_A5A5;
    @(negedge clk);
    req_valid = 1'b0;
    data_sram_addr_ok = 1'b1; data_sram_data_ok = 1'b1;
    chk("ale_k0_req", data_sram_req, 0);
    chk("ale_k0_rv", resp_valid, 0);
    @(negedge clk);
    data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0;
    chk("ale_rv", resp_valid, 1);
    chk("ale_flag", resp_ale, 1);
    chk("ale_rd", resp_rdata, 0);
    chk("ale_req", data_sram_req, 0);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("ale_done", req_ready, 1);
    chk("ale_clr", resp_ale, 0);
`else
    txn(1'b0, 2'b11, 1'b0, 32'h0000_3002, 32'h0, 32'hA5A5_A5A5);
    chk("mis_addr", s_addr, 32'h0000_3002);
    chk("mis_req1", s_req1, 1);
    chk("mis_ale", s_ale, 0);
    chk("mis_rd", s_rd, 32'hA5A5_A5A5);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
LSU_MEM_CTRL -- requirements
Module: lsu_mem_ctrl

Interface
REQ-001 Parameter ADDR_W, default 32, address width of the pipeline request and the data-SRAM address.
REQ-002 Ports, listed as name, direction, width, meaning:
  clk  in  1  single clock; all state updates on its rising edge.
  resetn  in  1  asynchronous, active-low reset.
  req_valid  in  1  pipeline memory request valid.
  req_ready  out  1  controller can accept a request.
  req_wr  in  1  1 = store, 0 = load.
  req_len  in  2  access length: 00 byte, 01 half, 11 word (10 treated as word).
  req_sign  in  1  1 = sign-extend load result, 0 = zero-extend.
  req_addr  in  ADDR_W  byte address.
  req_wdata  in  32  store data, right-aligned.
  resp_valid  out  1  response valid.
  resp_ready  in  1  pipeline accepts the response.
  resp_rdata  out  32  extended load data; 0 for stores.
  resp_ale  out  1  misaligned-access flag (REQ-016).
  data_sram_req  out  1  bus request.
  data_sram_wr  out  1  bus write.
  data_sram_size  out  2  0 byte, 1 half, 2 word.
  data_sram_wstrb  out  4  byte strobes.
  data_sram_addr  out  ADDR_W  bus address.
  data_sram_wdata  out  32  lane-replicated store data.
  data_sram_addr_ok  in  1  bus accepted the address phase.
  data_sram_data_ok  in  1  bus completed the data phase.
  data_sram_rdata  in  32  raw load word.

Function
REQ-003 FSM states: IDLE, ADDR, DATA, RESP.
REQ-004 req_ready SHALL be 1 only in IDLE; a request is captured when req_valid & req_ready, and the FSM enters ADDR on the next cycle.
REQ-005 All request fields SHALL be registered at capture; bus outputs SHALL be driven only from registers.
REQ-006 In ADDR, data_sram_req=1; on addr_ok go to DATA and drop data_sram_req in the same edge.
REQ-007 In DATA, on data_ok go to RESP; data_ok in the same cycle as addr_ok SHALL NOT be accepted (at most one transaction outstanding).
REQ-008 In RESP, resp_valid=1 and is held stable until resp_ready; on acceptance return to IDLE. No bubble is required between requests beyond the IDLE cycle.
REQ-009 Minimum latency: capture edge to resp_valid = 3 cycles (addr_ok and data_ok each on their first possible cycle).
REQ-010 wstrb: byte 0001 shifted left by addr[1:0]; half 0011 shifted left by {addr[1],0}; word 1111; loads drive wstrb 0000.
REQ-011 wdata: byte replicated ×4, half replicated ×2, word passed through.
REQ-012 Load result is registered at data_ok: byte lane addr[1:0]; half lane addr[1]; extension bit = lane MSB & sign; word passed through.
REQ-013 data_ok outside DATA and addr_ok outside ADDR SHALL be ignored.

Reset
REQ-014 resetn low SHALL force IDLE immediately: req_ready=1, resp_valid=0, data_sram_req=0, resp_ale=0, resp_rdata=0, and all other bus outputs 0.
REQ-015 Reset during ADDR/DATA SHALL abandon the transaction; a late data_ok after reset release SHALL be ignored.

Configuration
REQ-016 Macro LSU_ALIGN_CHECK_EN defined: a half access with addr[0]=1, or a word access with addr[1:0]≠0, skips ADDR/DATA and goes straight to RESP with resp_ale=1, resp_rdata=0, and no bus request. Macro undefined: resp_ale is tied 0 and the address is issued unchanged.

Structure
REQ-017 A shared package SHALL hold the length encodings (LEN_BYTE, LEN_HALF, LEN_WORD), the FSM state enum, and the size encodings.
REQ-018 Load alignment/extension SHALL be a combinational sub-module, lsu_load_ext, instantiated once.

Verification
REQ-019 lb: addr 0x...3, sign=1, rdata 0x80FF_0000 -> resp_rdata 0xFFFF_FF80.
REQ-020 lhu: addr 0x...2, sign=0, rdata 0x8001_1234 -> resp_rdata 0x0000_8001.
REQ-021 sb: addr 0x...1, wdata 0x0000_00AB -> wstrb 0010, bus wdata 0xABAB_ABAB, resp_rdata 0.
REQ-022 addr_ok delayed 4 cycles, data_ok delayed 3 cycles, resp_ready low 2 cycles -> data_sram_req high exactly 5 cycles, resp_valid held 3 cycles, req_ready low throughout.
REQ-023 resetn pulsed low in DATA, then a spurious data_ok -> IDLE, no resp_valid.
REQ-024 With LSU_ALIGN_CHECK_EN: lw at 0x...2 -> resp_ale=1 two cycles after capture, data_sram_req never asserted.
